// File: rtl/adquisicion_temp.sv
// Temperature acquisition front-end: periodic SPI mode-0 read of a 12-bit ADC, scaled to 0.1 degC steps.
// Optional 4-sample moving average of good readings when PROMEDIO_EN is defined.
module adquisicion_temp #(
    parameter int DIV_SCLK        = 4,
    parameter int PERIODO_MUESTRA = 1000,
    parameter int FALLOS_MAX      = 3,
    parameter int TEMP_RESET      = 220
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       habilitar,
    output logic       spi_sclk,
    output logic       spi_cs_n,
    input  logic       spi_miso,
    output logic [9:0] temp_salida,
    output logic       temp_valida,
    output logic       sensor_fallo,
    output logic [7:0] muestra_cnt
);

    localparam int DIV_W = $clog2(DIV_SCLK + 1);
    localparam int TIM_W = $clog2(PERIODO_MUESTRA + 1);
    localparam logic [DIV_W-1:0] DIV_FIN  = DIV_W'(DIV_SCLK - 1);
    localparam logic [TIM_W-1:0] TIM_FIN  = TIM_W'(PERIODO_MUESTRA - 1);
    localparam logic [3:0]       FMAX     = 4'(FALLOS_MAX);
    localparam logic [9:0]       TEMP_INI = 10'(TEMP_RESET);

    typedef enum logic [2:0] {
        REPOSO, ESPERA, SELECCION, TRANSFER, CIERRE, PROCESO
    } estado_t;

    estado_t          r_estado;
    logic [DIV_W-1:0] r_div;
    logic [4:0]       r_half;
    logic [TIM_W-1:0] r_timer;
    logic [15:0]      r_shift;
    logic             r_sclk;
    logic             r_cs_n;
    logic [9:0]       r_temp;
    logic             r_valida;
    logic             r_sensor_fallo;
    logic [7:0]       r_cnt;
    logic [3:0]       r_fallos;

    logic [11:0] w_raw;
    logic [9:0]  w_t;
    logic        w_trama_mala;
    logic [3:0]  w_fallos_inc;
    logic [9:0]  w_temp_nueva;

    assign w_raw        = r_shift[11:0];
    assign w_t          = w_raw[11:2];
    assign w_trama_mala = (r_shift[15:12] != 4'd0) || (w_raw == 12'h000) || (w_raw == 12'hFFF);
    assign w_fallos_inc = (r_fallos == FMAX) ? r_fallos : r_fallos + 4'd1;

`ifdef PROMEDIO_EN
    // Only the three previous samples are stored; the incoming t is the fourth term of the sum.
    logic [9:0]  r_win [0:2];
    logic        r_win_lleno;
    logic [11:0] w_suma;
    logic        w_win_carga;

    assign w_win_carga  = (r_estado == PROCESO) && !w_trama_mala;
    assign w_suma       = {2'b00, w_t} + {2'b00, r_win[0]} + {2'b00, r_win[1]} + {2'b00, r_win[2]};
    assign w_temp_nueva = r_win_lleno ? w_suma[11:2] : w_t;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_win
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_win[gi] <= 10'd0;
                end else if (w_win_carga) begin
                    if (gi == 0 || !r_win_lleno) begin
                        r_win[gi] <= w_t;
                    end else begin
                        r_win[gi] <= r_win[(gi == 0) ? 0 : gi - 1];
                    end
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_win_lleno <= 1'b0;
        end else if (w_win_carga) begin
            r_win_lleno <= 1'b1;
        end
    end
`else
    assign w_temp_nueva = w_t;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_estado       <= REPOSO;
            r_div          <= '0;
            r_half         <= 5'd0;
            r_timer        <= '0;
            r_shift        <= 16'd0;
            r_sclk         <= 1'b0;
            r_cs_n         <= 1'b1;
            r_temp         <= TEMP_INI;
            r_valida       <= 1'b0;
            r_sensor_fallo <= 1'b0;
            r_cnt          <= 8'd0;
            r_fallos       <= 4'd0;
        end else begin
            r_valida <= 1'b0;
            if (r_estado != REPOSO) begin
                r_timer <= r_timer + TIM_W'(1);
            end
            case (r_estado)
                REPOSO: begin
                    if (habilitar) begin
                        r_estado <= SELECCION;
                        r_cs_n   <= 1'b0;
                        r_sclk   <= 1'b0;
                        r_div    <= '0;
                        r_timer  <= '0;
                    end
                end
                ESPERA: begin
                    if (!habilitar) begin
                        r_estado <= REPOSO;
                    end else if (r_timer == TIM_FIN) begin
                        r_estado <= SELECCION;
                        r_cs_n   <= 1'b0;
                        r_sclk   <= 1'b0;
                        r_div    <= '0;
                        r_timer  <= '0;
                    end
                end
                SELECCION: begin
                    if (r_div == DIV_FIN) begin
                        r_estado <= TRANSFER;
                        r_div    <= '0;
                        r_half   <= 5'd0;
                        r_sclk   <= 1'b1;
                        r_shift  <= {r_shift[14:0], spi_miso};
                    end else begin
                        r_div <= r_div + DIV_W'(1);
                    end
                end
                TRANSFER: begin
                    // Even half-periods are sclk high, odd ones low; sample when entering a high half.
                    if (r_div == DIV_FIN) begin
                        r_div <= '0;
                        if (r_half == 5'd31) begin
                            r_estado <= CIERRE;
                            r_cs_n   <= 1'b1;
                            r_sclk   <= 1'b0;
                        end else begin
                            r_half <= r_half + 5'd1;
                            r_sclk <= ~r_sclk;
                            if (r_half[0]) begin
                                r_shift <= {r_shift[14:0], spi_miso};
                            end
                        end
                    end else begin
                        r_div <= r_div + DIV_W'(1);
                    end
                end
                CIERRE: begin
                    if (r_div == DIV_FIN) begin
                        r_estado <= PROCESO;
                        r_div    <= '0;
                    end else begin
                        r_div <= r_div + DIV_W'(1);
                    end
                end
                PROCESO: begin
                    r_estado <= habilitar ? ESPERA : REPOSO;
                    if (!w_trama_mala) begin
                        r_temp         <= w_temp_nueva;
                        r_valida       <= 1'b1;
                        r_cnt          <= r_cnt + 8'd1;
                        r_fallos       <= 4'd0;
                        r_sensor_fallo <= 1'b0;
                    end else begin
                        r_fallos       <= w_fallos_inc;
                        r_sensor_fallo <= (w_fallos_inc == FMAX);
                    end
                end
                default: r_estado <= REPOSO;
            endcase
        end
    end

    assign spi_sclk     = r_sclk;
    assign spi_cs_n     = r_cs_n;
    assign temp_salida  = r_temp;
    assign temp_valida  = r_valida;
    assign sensor_fallo = r_sensor_fallo;
    assign muestra_cnt  = r_cnt;

endmodule

// File: tb/tb_adquisicion_temp.sv
// Scoreboard bench for adquisicion_temp: ADC responder model, pulse monitor, directed frame sequence.
module tb_adquisicion_temp;

    localparam int D = 2;
    localparam int P = 100;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       habilitar = 1'b0;
    logic       spi_sclk;
    logic       spi_cs_n;
    logic       spi_miso = 1'b0;
    logic [9:0] temp_salida;
    logic       temp_valida;
    logic       sensor_fallo;
    logic [7:0] muestra_cnt;

    adquisicion_temp #(
        .DIV_SCLK(D), .PERIODO_MUESTRA(P), .FALLOS_MAX(3), .TEMP_RESET(220)
    ) dut (
        .clk(clk), .rst(rst), .habilitar(habilitar),
        .spi_sclk(spi_sclk), .spi_cs_n(spi_cs_n), .spi_miso(spi_miso),
        .temp_salida(temp_salida), .temp_valida(temp_valida),
        .sensor_fallo(sensor_fallo), .muestra_cnt(muestra_cnt)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_mis = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_mis++;
            $display("FAIL %s: got %0d required %0d", nm, act, req);
        end
    endtask

    // ADC responder: loads a word on cs_n fall, shifts on sclk fall
    logic [15:0] adc_q[$];
    logic [15:0] adc_word = 16'h0FFF;
    int          adc_bit = 15;
    logic        adc_prev_cs = 1'b1;
    logic        adc_prev_sclk = 1'b0;
    always @(negedge clk) begin
        if (adc_prev_cs === 1'b1 && spi_cs_n === 1'b0) begin
            if (adc_q.size() > 0) adc_word = adc_q.pop_front();
            else adc_word = 16'h0FFF;
            adc_bit = 15;
        end else if (spi_cs_n === 1'b0 && adc_prev_sclk === 1'b1 && spi_sclk === 1'b0 && adc_bit > 0) begin
            adc_bit--;
        end
        spi_miso = adc_word[adc_bit];
        adc_prev_cs = spi_cs_n;
        adc_prev_sclk = spi_sclk;
    end

    // Scoreboard entries: {temp, sensor_fallo, muestra_cnt}
    logic [18:0] exp_q[$];
    logic [7:0]  exp_cnt = 8'd0;

    task automatic issue(input logic [15:0] w, input bit good, input logic [9:0] t);
        adc_q.push_back(w);
        if (good) begin
            exp_cnt++;
            exp_q.push_back({t, 1'b0, exp_cnt});
        end
    endtask

    // Monitor
    logic prev_cs = 1'b1;
    logic prev_sclk = 1'b0;
    bit   abort = 1'b0;
    bit   pend = 1'b0;
    int   cs_fall_cyc = 0;
    int   cs_rise_cyc = 0;
    int   cs_falls = 0;
    int   cs_low = 0;
    int   sclk_rises = 0;
    int   frames_done = 0;
    int   nval = 0;
    int   vcyc[64];
    always @(negedge clk) begin
        logic [18:0] e;
        if (prev_cs === 1'b1 && spi_cs_n === 1'b0) begin
            cs_fall_cyc = cyc;
            cs_falls++;
            cs_low = 0;
            sclk_rises = 0;
        end
        if (spi_cs_n === 1'b0) cs_low++;
        if (prev_sclk === 1'b0 && spi_sclk === 1'b1) sclk_rises++;
        if (prev_cs === 1'b0 && spi_cs_n === 1'b1 && !abort) begin
            chk("cs_low_cycles", cs_low, 33 * D);
            chk("sclk_rising_edges", sclk_rises, 16);
            cs_rise_cyc = cyc;
            pend = 1'b1;
        end
        if (pend && cyc == cs_rise_cyc + D + 1) begin
            frames_done++;
            pend = 1'b0;
        end
        if (temp_valida === 1'b1) begin
            if (nval < 64) vcyc[nval] = cyc;
            nval++;
            $display("pulse %0d cyc=%0d temp=%0d fallo=%0d cnt=%0d", nval, cyc, temp_salida, sensor_fallo, muestra_cnt);
            if (exp_q.size() == 0) begin
                chk("unexpected_pulse", 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk("pulse_temp", temp_salida, e[18:9]);
                chk("pulse_fallo", sensor_fallo, e[8]);
                chk("pulse_cnt", muestra_cnt, e[7:0]);
                chk("pulse_latency", cyc - cs_fall_cyc, 34 * D + 1);
            end
        end
        prev_cs = spi_cs_n;
        prev_sclk = spi_sclk;
    end

    task automatic wait_frames(input int n);
        for (int i = 0; i < 5000 && frames_done < n; i++) begin
            @(negedge clk);
            #1;
        end
        chk("frames_reached", frames_done, n);
    endtask

    task automatic wait_falls(input int n);
        for (int i = 0; i < 5000 && cs_falls < n; i++) begin
            @(negedge clk);
            #1;
        end
        chk("cs_falls_reached", cs_falls, n);
    endtask

    int en_cyc;
    int falls_snap;

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst_cs_n", spi_cs_n, 1);
        chk("rst_sclk", spi_sclk, 0);
        chk("rst_temp", temp_salida, 220);
        chk("rst_valida", temp_valida, 0);
        chk("rst_fallo", sensor_fallo, 0);
        chk("rst_cnt", muestra_cnt, 0);
        rst = 1'b0;

`ifdef PROMEDIO_EN
        issue(16'h0370, 1, 10'd220);
        issue(16'h0370, 1, 10'd220);
        issue(16'h0370, 1, 10'd220);
        issue(16'h0410, 1, 10'd230);
        issue(16'h0410, 1, 10'd240);
        issue(16'h0410, 1, 10'd250);
        issue(16'h0410, 1, 10'd260);
        @(negedge clk);
        habilitar = 1'b1;
        en_cyc = cyc;
        wait_falls(1);
        chk("start_after_enable", cs_fall_cyc, en_cyc + 1);
        wait_falls(7);
        habilitar = 1'b0;
        wait_frames(7);
`else
        issue(16'h0370, 1, 10'd220);
        issue(16'h02C8, 1, 10'd178);
        issue(16'h0410, 1, 10'd260);
        issue(16'h0370, 1, 10'd220);
        issue(16'h0FFF, 0, 10'd0);
        issue(16'h0FFF, 0, 10'd0);
        issue(16'h0FFF, 0, 10'd0);
        issue(16'h0370, 1, 10'd220);
        issue(16'h1370, 0, 10'd0);
        issue(16'h0000, 0, 10'd0);
        issue(16'h0FFF, 0, 10'd0);
        issue(16'h02C8, 1, 10'd178);
        issue(16'h0410, 1, 10'd260);
        @(negedge clk);
        habilitar = 1'b1;
        en_cyc = cyc;
        wait_falls(1);
        chk("start_after_enable", cs_fall_cyc, en_cyc + 1);
        wait_frames(3);
        chk("spacing_1_2", vcyc[1] - vcyc[0], P);
        chk("spacing_2_3", vcyc[2] - vcyc[1], P);
        wait_frames(6);
        chk("fallo_after_2_bad", sensor_fallo, 0);
        wait_frames(7);
        chk("fallo_after_3_bad", sensor_fallo, 1);
        chk("temp_held_bad", temp_salida, 220);
        chk("cnt_held_bad", muestra_cnt, 4);
        wait_frames(8);
        chk("spacing_4_8", vcyc[4] - vcyc[3], 4 * P);
        wait_frames(9);
        chk("hdr_bad_fallo", sensor_fallo, 0);
        chk("hdr_bad_temp", temp_salida, 220);
        chk("hdr_bad_cnt", muestra_cnt, 5);
        wait_frames(10);
        chk("zero_bad_fallo", sensor_fallo, 0);
        wait_frames(11);
        chk("third_bad_fallo", sensor_fallo, 1);
        wait_falls(13);
        habilitar = 1'b0;
        wait_frames(13);
`endif
        falls_snap = cs_falls;
        repeat (300) @(negedge clk);
        #1;
        chk("idle_after_disable", cs_falls, falls_snap);

        // Reset in the middle of a transfer
        abort = 1'b1;
        adc_q.push_back(16'h0410);
        habilitar = 1'b1;
        wait_falls(falls_snap + 1);
        repeat (20) @(negedge clk);
        rst = 1'b1;
        habilitar = 1'b0;
        @(negedge clk);
        #1;
        chk("midrst_cs_n", spi_cs_n, 1);
        chk("midrst_sclk", spi_sclk, 0);
        chk("midrst_temp", temp_salida, 220);
        chk("midrst_cnt", muestra_cnt, 0);
        chk("midrst_valida", temp_valida, 0);
        rst = 1'b0;
        falls_snap = cs_falls;
        repeat (200) @(negedge clk);
        #1;
        chk("no_frame_without_enable", cs_falls, falls_snap);

        abort = 1'b0;
        exp_cnt = 8'd0;
        issue(16'h0370, 1, 10'd220);
        frames_done = 0;
        habilitar = 1'b1;
        en_cyc = cyc;
        wait_falls(falls_snap + 1);
        chk("restart_after_enable", cs_fall_cyc, en_cyc + 1);
        habilitar = 1'b0;
        wait_frames(1);
        repeat (5) @(negedge clk);
        #1;
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/adquisicion_temp.md
Name: adquisicion_temp

Overview:
- Temperature acquisition front-end. Its output drives the `temp_entrada` input of `monitoreo_top`, so it is the producer side of that temperature interface.
- Periodically reads a 12-bit serial temperature ADC as SPI-mode-0 master and receiver, and converts each raw code to the monitor's 10-bit scale (one LSB = 0.1 °C). Example: 220 = 22.0 °C.
- Holds the last good value between conversions, flags one-cycle updates and detects persistent sensor faults.

Parameters:
- DIV_SCLK, 4: clk cycles per spi_sclk half-period (≥1).
- PERIODO_MUESTRA, 1000: clk cycles between conversion starts. Must be ≥ 40*DIV_SCLK.
- FALLOS_MAX, 3: consecutive faulty frames before sensor_fallo asserts (1..15).
- TEMP_RESET, 220: temp_salida value after reset.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- habilitar  in  1  enables periodic conversions
- spi_sclk  out  1  ADC serial clock, idle low
- spi_cs_n  out  1  ADC chip select, active low
- spi_miso  in  1  ADC serial data
- temp_salida  out  10  temperature to monitoreo_top.temp_entrada
- temp_valida  out  1  one-cycle pulse on each temp_salida update
- sensor_fallo  out  1  persistent sensor fault flag
- muestra_cnt  out  8  count of good samples, wraps 255→0

Behaviour:
- One clock, clk. Reset rst is synchronous and active-high; every register, including mid-frame state, is reset by it.
- Reset values:
  - spi_cs_n=1, spi_sclk=0
  - temp_salida=TEMP_RESET, temp_valida=0, sensor_fallo=0, muestra_cnt=0
  - fault counter=0, period timer=0, FSM=REPOSO
- FSM states, REPOSO→ESPERA→SELECCION→TRANSFER→CIERRE→PROCESO→ESPERA:
  - REPOSO: idle. Goes to SELECCION on the clk after habilitar=1 is sampled. The period timer restarts there.
  - ESPERA: waits until the period timer reaches PERIODO_MUESTRA-1, then goes to SELECCION and clears the timer. If habilitar=0, goes to REPOSO instead.
  - SELECCION: spi_cs_n=0 for one half-period (DIV_SCLK clks), sclk low.
  - TRANSFER: 16 sclk periods. spi_miso is sampled on the clk where sclk rises, MSB first, into a 16-bit shift register. sclk returns low at the end.
  - CIERRE: spi_cs_n=1 for one half-period.
  - PROCESO: one clk. Evaluates the frame; outputs update on the following clk edge.
- habilitar falling mid-frame: the current frame completes and is processed, then the FSM goes to REPOSO. There is never a partial frame.
- Frame format: bits[15:12] must be 0; raw = bits[11:0].
- Faulty frame, when any of the following holds:
  - bits[15:12] ≠ 0
  - raw = 12'h000
  - raw = 12'hFFF
- Good frame handling:
  - Conversion: t = raw[11:2]. The top 10 bits are kept; there is no rounding.
  - temp_salida is updated (see Optional Feature); temp_valida pulses for 1 clk; muestra_cnt increments.
  - Fault counter clears; sensor_fallo clears in the same cycle.
- Faulty frame handling:
  - temp_salida holds; no temp_valida pulse.
  - Fault counter increments and saturates at FALLOS_MAX.
  - sensor_fallo=1 once the counter reaches FALLOS_MAX. It is sticky until the next good frame.
- Latency: temp_valida/temp_salida change exactly 1 clk after PROCESO. Nominal frame length from SELECCION entry = 34*DIV_SCLK+1 clks.
- Sampling is strictly periodic while enabled: the start-to-start spacing is exactly PERIODO_MUESTRA clks.

Optional Feature:
- Macro: PROMEDIO_EN.
- Defined:
  - temp_salida = (sum of last 4 good t values) >> 2, using a 12-bit sum and truncating.
  - The first good sample after reset fills all 4 window slots, so there is no ramp from TEMP_RESET.
  - Faulty frames do not enter the window.
  - Same latency.
- Undefined: temp_salida = t directly; no window registers.

Test Plan (bench uses DIV_SCLK=2, PERIODO_MUESTRA=100, FALLOS_MAX=3):
- Reset then habilitar=1, ADC returns raw 0x370 → temp_salida=220, temp_valida 1-clk pulse 69 clks after SELECCION entry, muestra_cnt=1. spi_cs_n low for exactly 66 clks; 16 sclk rising edges.
- ADC raw 0x2C8 then 0x410 (no PROMEDIO_EN) → temp_salida 178, then 260. Consecutive temp_valida pulses exactly 100 clks apart.
- ADC raw 0xFFF for 3 frames → temp_salida held at 220, no temp_valida, sensor_fallo=1 after the 3rd PROCESO. Next raw 0x370 → sensor_fallo=0 and temp_valida pulses in the same cycle.
- Frame with bits[15:12]=4'b0001 → treated as faulty, fault counter=1, outputs held.
- rst asserted while in TRANSFER → next clk: spi_cs_n=1, spi_sclk=0, temp_salida=220, muestra_cnt=0. A new frame starts only after habilitar is sampled high again.
- PROMEDIO_EN: raw 0x370 ×3 then 0x410 → temp_salida 220,220,220,230. Then 0x410 ×3 more → 240,250,260.
